// File: rtl/pos_derivative_lookup_ctrl.sv
// Positive-derivative table lookup engine: quantises membrane potentials to ROM addresses,
// realigns the 1-cycle ROM read with its neuron index and buffers results for the STDP path.
module pos_derivative_lookup_ctrl #(
    parameter int POT_WIDTH  = 16,
    parameter int IDX_WIDTH  = 8,
    parameter int SHIFT      = 4,
    parameter int OFFSET     = 128,
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [POT_WIDTH-1:0] s_potential,
    input  logic        [IDX_WIDTH-1:0] s_idx,
    output logic       [ADDR_WIDTH-1:0] rom_addr,
    input  logic       [DATA_WIDTH-1:0] rom_dout,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic       [DATA_WIDTH-1:0] m_deriv,
    output logic        [IDX_WIDTH-1:0] m_idx,
    input  logic                        clr_cnt,
    output logic        [CNT_WIDTH-1:0] nz_count,
    output logic                        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = POT_WIDTH + 2;
    localparam logic signed [TW-1:0] OFF_S      = TW'(OFFSET);
    localparam logic signed [TW-1:0] ADDR_MAX_S = TW'((1 << ADDR_WIDTH) - 1);

    // Shift, recentre and clamp a potential onto the table address range.
    function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic signed [POT_WIDTH-1:0] pot);
        logic signed [POT_WIDTH-1:0] sh;
        logic signed [TW-1:0]        t;
        sh = pot >>> SHIFT;
        t  = sh + OFF_S;
        if (t[TW-1])
            return '0;
        else if (t > ADDR_MAX_S)
            return '1;
        else
            return t[ADDR_WIDTH-1:0];
    endfunction

    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  vld_p0_q, vld_p1_q;
    logic [IDX_WIDTH-1:0]  idx_p0_q, idx_p1_q;

    logic [DATA_WIDTH-1:0] deriv_mem_q [FIFO_DEPTH];
    logic [IDX_WIDTH-1:0]  idx_mem_q   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d, occ;
    logic [CNT_WIDTH-1:0]  nz_q, nz_d;

    logic in_xfer, push, pop;

    // Credits count everything already committed downstream of the input, so the ROM
    // return path can always be absorbed without stalling.
    assign occ     = cnt_q + CW'(vld_p0_q) + CW'(vld_p1_q);
    assign s_ready = occ < CW'(FIFO_DEPTH);
    assign in_xfer = s_valid & s_ready;
    assign push    = vld_p1_q;
    assign m_valid = cnt_q != '0;
    assign pop     = m_valid & m_ready;

    assign rom_addr = rom_addr_q;
    assign m_deriv  = m_valid ? deriv_mem_q[rd_ptr_q] : '0;
    assign m_idx    = m_valid ? idx_mem_q[rd_ptr_q]   : '0;
    assign nz_count = nz_q;
    assign busy     = vld_p0_q | vld_p1_q | m_valid;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        nz_d = nz_q;
        if (clr_cnt)
            nz_d = '0;
        else if (pop && (m_deriv != '0) && !(&nz_q))
            nz_d = nz_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            nz_q       <= '0;
        end else begin
            // Stage p0: address register feeding the ROM
            vld_p0_q <= in_xfer;
            if (in_xfer)
                rom_addr_q <= map_addr(s_potential);
            // Stage p1: ROM output valid, realigned with its index
            vld_p1_q <= vld_p0_q;
            // Output buffer
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            nz_q  <= nz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer)
            idx_p0_q <= s_idx;
        idx_p1_q <= idx_p0_q;
        if (push) begin
            deriv_mem_q[wr_ptr_q] <= rom_dout;
            idx_mem_q[wr_ptr_q]   <= idx_p1_q;
        end
    end

endmodule
